// File: rtl/dmg_link_pkg.sv
// Shared definitions for the DMG link-cable peer: FSM encoding and link constants.
package dmg_link_pkg;

    localparam int   LINK_BITS = 8;
    localparam logic SCK_IDLE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } link_state_e;

endpackage

// File: rtl/dmg_link_sync.sv
// Multi-flop synchronizer for an asynchronous link wire, with registered edge
// pulses taken from the synchronized level.
module dmg_link_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Everything resets high so an idle-high wire never produces an edge out of reset.
    always_ff @(posedge clk) begin
        if (res) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
            rise_q <= chain_q[STAGES-1] & ~prev_q;
            fall_q <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign q    = chain_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/dmg_link_peer.sv
// DMG link-cable partner: swaps one byte per transfer over SCK/SIN/SOUT, MSB first,
// either following the DMG's clock (slave) or generating SCK itself (master).
//   state | meaning
//   IDLE  | ready for a byte, SCK edges ignored, sout/sck_out held high
//   XFER  | shifting: sample on SCK rise, drive sout on SCK fall
//   DONE  | one cycle: rx_data updated, rx_valid pulsed
module dmg_link_peer
    import dmg_link_pkg::*;
#(
    parameter int CLK_DIV     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 master,
    input  logic                 sck_in,
    output logic                 sck_out,
    output logic                 sck_oe,
    input  logic                 sin,
    output logic                 sout,
    input  logic [LINK_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [LINK_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);

    localparam int             DIV_W    = $clog2(CLK_DIV + 1);
    localparam int             CNT_W    = $clog2(LINK_BITS);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINK_BITS - 1);

    link_state_e          state_q, state_d;
    logic [LINK_BITS-1:0] sr_q, sr_d;
    logic [LINK_BITS-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sck_q, sck_d;
    logic                 sout_q, sout_d;
    logic                 mode_q, mode_d;

    logic                 sck_sync_unused;
    logic                 sck_rise, sck_fall;
    logic                 sin_sync;
    logic [1:0]           sin_edges_unused;
    logic                 div_tc, bit_rise, bit_fall;

    dmg_link_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk  (clk),
        .res  (res),
        .d    (sck_in),
        .q    (sck_sync_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    dmg_link_sync #(.STAGES(SYNC_STAGES)) u_sync_sin (
        .clk  (clk),
        .res  (res),
        .d    (sin),
        .q    (sin_sync),
        .rise (sin_edges_unused[0]),
        .fall (sin_edges_unused[1])
    );

    // In master mode the divider terminal count is the SCK toggle; its direction decides the edge.
    assign div_tc   = (div_q == '0);
    assign bit_rise = mode_q ? (div_tc & ~sck_q) : sck_rise;
    assign bit_fall = mode_q ? (div_tc &  sck_q) : sck_fall;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            sr_q      <= '1;
            rx_data_q <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            sck_q     <= SCK_IDLE;
            sout_q    <= 1'b1;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            sout_q    <= sout_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sck_d     = sck_q;
        sout_d    = sout_q;
        mode_d    = mode_q;
        tx_ready  = 1'b0;
        busy      = 1'b1;
        rx_valid  = 1'b0;
        sck_out   = SCK_IDLE;
        sck_oe    = mode_q;
        sout      = 1'b1;

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                sck_oe   = master;
                if (tx_valid) begin
                    sr_d    = tx_data;
                    sout_d  = tx_data[LINK_BITS-1];
                    mode_d  = master;
                    cnt_d   = '0;
                    div_d   = DIV_LOAD;
                    sck_d   = SCK_IDLE;
                    state_d = XFER;
                end
            end
            XFER: begin
                sout    = sout_q;
                sck_out = mode_q ? sck_q : SCK_IDLE;
                if (mode_q) begin
                    if (div_tc) begin
                        div_d = DIV_LOAD;
                        sck_d = ~sck_q;
                    end else begin
                        div_d = div_q - 1'b1;
                    end
                end
                if (bit_rise) begin
                    sr_d  = {sr_q[LINK_BITS-2:0], sin_sync};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d = {sr_q[LINK_BITS-2:0], sin_sync};
                        cnt_d     = '0;
                        state_d   = DONE;
                    end
                end
                if (bit_fall) begin
                    sout_d = sr_q[LINK_BITS-1];
                end
            end
            DONE: begin
                rx_valid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data = rx_data_q;

endmodule
